mux_pipe_col: RTL and testbench
===============================

# mux_pipe_col

Parametrised, pipelined N:1 column multiplexer with valid/ready flow control, the successor to the flat combinational column mux in the memory column datapath. Reduces NUM_ELEM input elements through a radix-RADIX tree, registering every level. Throughput is one transfer per cycle, latency is fixed, and per-stage backpressure collapses bubbles. Out-of-range selects (NUM_ELEM not a power of two) return zero and raise an error flag instead of aliasing.

## Interface
- ELEM_WIDTH, default 1: width of each input element and of the output.
- NUM_ELEM, default 1024: number of input elements; any value ≥ 2.
- RADIX, default 4: inputs per tree node; power of two, 2..NUM_ELEM.
- Derived:
  - SW = $clog2(NUM_ELEM)
  - R = $clog2(RADIX)
  - L = ceil(SW/R) pipeline stages, minimum 1
- clk_i, input, 1: single clock, rising edge.
- arst_ni, input, 1: reset, asynchronous, active-low.
- s_i, input, SW: element select, sampled on accept.
- i_i, input, NUM_ELEM×ELEM_WIDTH: packed element array, sampled on accept.
- i_valid_i, input, 1: request valid.
- i_ready_o, output, 1: stage 0 can accept.
- o_o, output, ELEM_WIDTH: selected element.
- o_err_o, output, 1: select was ≥ NUM_ELEM; o_o is 0.
- o_valid_o, output, 1: o_o/o_err_o valid.
- o_ready_i, input, 1: downstream accepts.

## Operation
- Pad the input array with zeros to RADIX^L elements.
- Stage k (0..L-1) uses select bits [k·R +: R]. Select bits at or above SW are treated as 0. Each node picks one of RADIX children.
- Stage 0 node j outputs element j·RADIX + s[R-1:0]. Later stages operate on the previous stage's reduced array.
- Each stage registers:
  - its reduced array (RADIX^(L-1-k) elements),
  - the unconsumed select bits,
  - an err bit,
  - a valid bit.
- Stage L-1 register drives o_o, o_err_o and o_valid_o.
- err is computed at accept time as (s_i ≥ NUM_ELEM) and carried down the pipeline. When err is set, the output data is forced to 0.
- Flow control, with stage L as the output port:
  - Stage k loads when valid_{k+1} = 0, or when stage k+1 is loading. For k = L-1 the condition is o_valid_o = 0 or o_ready_i = 1.
  - i_ready_o = stage 0 load condition.
  - Accept occurs when i_valid_i & i_ready_o.
- A stage that loads with no valid upstream data clears its valid bit. Data registers may hold stale values when valid = 0.
- A held stage (valid and not advancing) keeps all of its registers unchanged.
- No combinational path from i_valid_i to o_o. i_ready_o is combinational from o_ready_i through the valid chain; no other comb paths.

## Timing
- Reset (arst_ni low, asynchronous): all valid bits, o_valid_o, o_err_o and o_o are 0. The data registers of stages 0..L-2 may also be reset; it is not required.
- After arst_ni deasserts, i_ready_o = 1 in the first cycle.
- Latency: a request accepted at edge n appears on o_o with o_valid_o = 1 after edge n+L-1, i.e. L cycles after i_valid_i was presented, when unstalled.
- Throughput: one accept per cycle while o_ready_i = 1.
- Output stall:
  - o_o, o_err_o and o_valid_o stay stable until the cycle in which o_valid_o & o_ready_i.
  - Upstream stages continue filling bubbles.
  - i_ready_o falls only when all L stages are valid and o_ready_i = 0.
- Simultaneous output pop and input accept while full: both occur, no loss, no duplication.
- Reset mid-operation: all in-flight transfers are discarded and o_valid_o drops asynchronously.
- L = 1 case (RADIX ≥ NUM_ELEM rounded up): a single registered stage, i_ready_o = !o_valid_o | o_ready_i.

## Test plan
- Reset check: NUM_ELEM=1024, RADIX=4 (L=5). Hold arst_ni low -> o_valid_o=0, o_o=0, o_err_o=0. After release -> i_ready_o=1.
- Latency sweep: i_i[k]=k (ELEM_WIDTH=10), o_ready_i=1, back-to-back selects 0, 1, 511, 1023 -> outputs 0, 1, 511, 1023 in order, each exactly 5 cycles after its accept, one per cycle.
- Backpressure: o_ready_i=0 for 8 cycles while streaming -> exactly 5 accepts, then i_ready_o=0. o_o is held stable. On release, all 5 drain in order with no drops or duplicates.
- Bubble collapse: one accept, then idle, then o_ready_i=0 with one output pending -> the next request still accepts until the pipeline is full. Order is preserved.
- Non-power-of-two: NUM_ELEM=600, RADIX=8 (SW=10, L=4), i_i[k]=k+1.
  - s_i=599 -> o_o=600, o_err_o=0.
  - s_i=600 and s_i=1023 -> o_o=0, o_err_o=1.
- Reset mid-stream: assert arst_ni with 3 transfers in flight -> o_valid_o falls immediately. After release, no stale outputs appear, and the first new request returns the correct data after 5 cycles.

Source files
------------

// File: rtl/mux_pipe_col_if.sv
// Request/response bundle for the pipelined column multiplexer.
// The requester side drives the select, the element array and the
// handshake toward the mux; the mux drives the result and i_ready_o.
interface mux_pipe_col_if #(
    parameter int ELEM_WIDTH = 1,
    parameter int NUM_ELEM   = 1024
);
    localparam int SW = $clog2(NUM_ELEM);

    logic [SW-1:0]                  s_i;
    logic [NUM_ELEM*ELEM_WIDTH-1:0] i_i;
    logic                           i_valid_i;
    logic                           i_ready_o;
    logic [ELEM_WIDTH-1:0]          o_o;
    logic                           o_err_o;
    logic                           o_valid_o;
    logic                           o_ready_i;

    modport master (
        output s_i, i_i, i_valid_i, o_ready_i,
        input  i_ready_o, o_o, o_err_o, o_valid_o
    );

    modport slave (
        input  s_i, i_i, i_valid_i, o_ready_i,
        output i_ready_o, o_o, o_err_o, o_valid_o
    );
endinterface

// File: rtl/mux_pipe_col.sv
// Pipelined N:1 column multiplexer. The element array is reduced through a
// radix-RADIX tree with one register stage per tree level; every stage has
// its own valid bit so bubbles collapse under output backpressure.
// Out-of-range selects (NUM_ELEM not a power of two) yield zero with o_err_o.
module mux_pipe_col #(
    parameter int ELEM_WIDTH = 1,
    parameter int NUM_ELEM   = 1024,
    parameter int RADIX      = 4
) (
    input logic           clk_i,
    input logic           arst_ni,
    mux_pipe_col_if.slave bus
);
    localparam int SW    = $clog2(NUM_ELEM);
    localparam int R     = $clog2(RADIX);
    localparam int L_RAW = (SW + R - 1) / R;
    localparam int L     = (L_RAW < 1) ? 1 : L_RAW;
    localparam int EW    = ELEM_WIDTH;

    logic [L-1:0] valid;
    logic [L-1:0] load;

    // Stage k may load unless it and every stage after it are occupied while
    // the output is stalled. Written flat so each bit depends only on the
    // valid bits and o_ready_i, never on another load bit.
    for (genvar k = 0; k < L; k++) begin : g_load
        assign load[k] = bus.o_ready_i | ~(&valid[L-1:k]);
    end

    for (genvar k = 0; k < L; k++) begin : g_stage
        localparam int N_OUT   = RADIX ** (L - 1 - k);
        localparam int N_IN    = N_OUT * RADIX;
        localparam int SEL_W   = (L - k) * R;
        localparam bit IS_LAST = (k == L - 1);

        logic [N_IN*EW-1:0]  din;
        logic [SEL_W-1:0]    sel_in;
        logic                err_in;
        logic                valid_in;
        logic [N_OUT*EW-1:0] data_d;
        logic [N_OUT*EW-1:0] data_q;
        logic                valid_q;
        logic                err_q;

        if (k == 0) begin : g_src
            // Zero-pad the element array to RADIX**L entries and the select
            // to L*R bits, so padded positions read as zero.
            always_comb begin
                din            = '0;
                din[NUM_ELEM*EW-1:0] = bus.i_i;
                sel_in         = '0;
                sel_in[SW-1:0] = bus.s_i;
            end
            assign err_in   = int'(bus.s_i) >= NUM_ELEM;
            assign valid_in = bus.i_valid_i;
        end else begin : g_src
            assign din      = g_stage[k-1].data_q;
            assign sel_in   = g_stage[k-1].g_fwd.sel_q;
            assign err_in   = g_stage[k-1].err_q;
            assign valid_in = g_stage[k-1].valid_q;
        end

        // Each node picks one of its RADIX children using the low select
        // bits; the final stage forces zero for an out-of-range select.
        always_comb begin
            int base;
            data_d = '0;
            base   = int'(sel_in[R-1:0]);
            if (!(IS_LAST && err_in)) begin
                for (int j = 0; j < N_OUT; j++) begin
                    data_d[j*EW +: EW] = din[(j*RADIX + base)*EW +: EW];
                end
            end
        end

        // Handshake state: a loading stage copies upstream valid/err, so a
        // load with nothing upstream leaves a bubble; a held stage keeps both.
        always_ff @(posedge clk_i or negedge arst_ni) begin
            if (!arst_ni) begin
                valid_q <= 1'b0;
                err_q   <= 1'b0;
            end else if (load[k]) begin
                valid_q <= valid_in;
                err_q   <= err_in;
            end
        end

        assign valid[k] = valid_q;

        if (IS_LAST) begin : g_data
            // Output data register, cleared on reset so o_o reads zero.
            always_ff @(posedge clk_i or negedge arst_ni) begin
                if (!arst_ni) begin
                    data_q <= '0;
                end else if (load[k]) begin
                    data_q <= data_d;
                end
            end
        end else begin : g_data
            // NOTE: wide intermediate data registers are not reset; the stage
            // valid bit guards them, so stale contents are never observed.
            always_ff @(posedge clk_i) begin
                if (load[k]) begin
                    data_q <= data_d;
                end
            end
        end

        if (!IS_LAST) begin : g_fwd
            logic [SEL_W-R-1:0] sel_q;

            // Forward only the select bits that later stages still consume.
            always_ff @(posedge clk_i) begin
                if (load[k]) begin
                    sel_q <= sel_in[SEL_W-1:R];
                end
            end
        end
    end

    assign bus.i_ready_o = load[0];
    assign bus.o_valid_o = valid[L-1];
    assign bus.o_err_o   = g_stage[L-1].err_q;
    assign bus.o_o       = g_stage[L-1].data_q;
endmodule

// File: tb/tb_mux_pipe_col.sv
// Bench for mux_pipe_col: a 1024:1 radix-4 instance (L=5) checked against a
// queue-based reference model, and a 600:1 radix-8 instance (L=4) checked
// against hand-computed values for in-range and out-of-range selects.
module tb_mux_pipe_col;
    localparam int EW    = 10;
    localparam int NA    = 1024;
    localparam int RA    = 4;
    localparam int LA    = 5;
    localparam int NB    = 600;
    localparam int RB    = 8;
    localparam int LB    = 4;
    localparam int LIMIT = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    mux_pipe_col_if #(.ELEM_WIDTH(EW), .NUM_ELEM(NA)) bus_a ();
    mux_pipe_col_if #(.ELEM_WIDTH(EW), .NUM_ELEM(NB)) bus_b ();

    mux_pipe_col #(.ELEM_WIDTH(EW), .NUM_ELEM(NA), .RADIX(RA)) dut_a (
        .clk_i   (clk),
        .arst_ni (rst_n),
        .bus     (bus_a)
    );

    mux_pipe_col #(.ELEM_WIDTH(EW), .NUM_ELEM(NB), .RADIX(RB)) dut_b (
        .clk_i   (clk),
        .arst_ni (rst_n),
        .bus     (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: an accepted request for select s must come out, in
    // acceptance order, as element s (or zero with err when s >= NA).
    typedef struct {
        logic [EW-1:0] data;
        logic          err;
        int            cyc;
    } item_t;

    logic [EW-1:0] elems_a [NA];
    item_t         exp_q [$];
    logic [EW-1:0] seen [$];
    bit            lat_chk    = 1'b0;
    bit            prev_stall = 1'b0;
    logic [EW-1:0] prev_o     = '0;
    logic          prev_err   = 1'b0;
    int            pops       = 0;

    int lat_exp [4] = '{0, 1, 511, 1023};
    int bp_exp  [7] = '{100, 101, 102, 103, 104, 200, 201};
    int bub_exp [5] = '{300, 310, 311, 312, 313};

    function automatic item_t model_a(input int s, input int c);
        item_t it;
        it.err  = (s >= NA);
        it.data = it.err ? '0 : elems_a[s];
        it.cyc  = c;
        return it;
    endfunction

    // Compare process: at each falling edge, a pending pop must match the
    // model head, a stalled output must hold, and an accept feeds the model.
    always @(negedge clk) begin
        item_t it;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 32'(bus_a.o_valid_o), 1);
                check("stall_hold_data", 32'(bus_a.o_o), 32'(prev_o));
                check("stall_hold_err", 32'(bus_a.o_err_o), 32'(prev_err));
            end
            if (bus_a.o_valid_o && bus_a.o_ready_i) begin
                check("output_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    check("out_data", 32'(bus_a.o_o), 32'(it.data));
                    check("out_err", 32'(bus_a.o_err_o), 32'(it.err));
                    if (lat_chk) check("out_latency", cyc - it.cyc, LA);
                    seen.push_back(bus_a.o_o);
                end
                pops++;
            end
            if (bus_a.i_valid_i && bus_a.i_ready_o) begin
                exp_q.push_back(model_a(int'(bus_a.s_i), cyc));
            end
            prev_stall = bus_a.o_valid_o && !bus_a.o_ready_i;
            prev_o     = bus_a.o_o;
            prev_err   = bus_a.o_err_o;
        end
    end

    // Present s until accepted; returns just after the accepting edge with
    // i_valid_i still high so calls chain back to back.
    task automatic send_a(input int s);
        int n = 0;
        bus_a.s_i       = 10'(s);
        bus_a.i_valid_i = 1'b1;
        @(negedge clk);
        while (!bus_a.i_ready_o && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL send_a_timeout: select %0d not accepted within %0d cycles", s, LIMIT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int n = 0;
        bus_a.i_valid_i = 1'b0;
        bus_a.o_ready_i = 1'b1;
        while (exp_q.size() != 0 && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= LIMIT) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Stream incrementing selects for a fixed number of cycles with the
    // output stalled; reports how many were accepted.
    task automatic stall_stream(input int cycles, input int s0, output int acc);
        int s;
        s   = s0;
        acc = 0;
        bus_a.o_ready_i = 1'b0;
        bus_a.s_i       = 10'(s);
        bus_a.i_valid_i = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_a.i_ready_o) begin
                acc++;
                s++;
            end
            @(posedge clk);
            #1;
            bus_a.s_i = 10'(s);
        end
        bus_a.i_valid_i = 1'b0;
    endtask

    task automatic probe_b(input int s, input int exp_data, input int exp_err);
        int c0;
        int n;
        bus_b.s_i       = 10'(s);
        bus_b.i_valid_i = 1'b1;
        @(negedge clk);
        check("b_ready", 32'(bus_b.i_ready_o), 1);
        c0 = cyc;
        @(posedge clk);
        #1;
        bus_b.i_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus_b.o_valid_o && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("b_latency", cyc - c0, LB);
        check("b_data", 32'(bus_b.o_o), exp_data);
        check("b_err", 32'(bus_b.o_err_o), exp_err);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int s0;
        int acc;
        int n;

        for (int k = 0; k < NA; k++) begin
            elems_a[k] = EW'(k);
            bus_a.i_i[k*EW +: EW] = EW'(k);
        end
        for (int k = 0; k < NB; k++) begin
            bus_b.i_i[k*EW +: EW] = EW'(k + 1);
        end
        bus_a.s_i = '0; bus_a.i_valid_i = 1'b0; bus_a.o_ready_i = 1'b0;
        bus_b.s_i = '0; bus_b.i_valid_i = 1'b0; bus_b.o_ready_i = 1'b1;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus_a.o_valid_o), 0);
        check("rst_data", 32'(bus_a.o_o), 0);
        check("rst_err", 32'(bus_a.o_err_o), 0);
        check("rst_valid_b", 32'(bus_b.o_valid_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(bus_a.i_ready_o), 1);
        @(posedge clk);
        #1;

        // Latency sweep: back-to-back selects, unstalled.
        bus_a.o_ready_i = 1'b1;
        lat_chk = 1'b1;
        p0 = pops;
        s0 = seen.size();
        send_a(0);
        send_a(1);
        send_a(511);
        send_a(1023);
        drain_a();
        lat_chk = 1'b0;
        check("lat_count", pops - p0, 4);
        for (int i = 0; i < 4; i++) check("lat_literal", 32'(seen[s0 + i]), lat_exp[i]);

        // Backpressure: 8 stalled cycles admit exactly L requests.
        p0 = pops;
        s0 = seen.size();
        stall_stream(8, 100, acc);
        check("bp_accepts", acc, LA);
        check("bp_ready_low", 32'(bus_a.i_ready_o), 0);
        bus_a.o_ready_i = 1'b1;
        send_a(200);
        send_a(201);
        drain_a();
        check("bp_count", pops - p0, 7);
        for (int i = 0; i < 7; i++) check("bp_literal", 32'(seen[s0 + i]), bp_exp[i]);

        // Bubble collapse: one item in flight, then stall and keep streaming.
        p0 = pops;
        s0 = seen.size();
        send_a(300);
        bus_a.i_valid_i = 1'b0;
        @(posedge clk);
        #1;
        stall_stream(6, 310, acc);
        check("bubble_accepts", acc, 4);
        check("bubble_ready_low", 32'(bus_a.i_ready_o), 0);
        drain_a();
        check("bubble_count", pops - p0, 5);
        for (int i = 0; i < 5; i++) check("bubble_literal", 32'(seen[s0 + i]), bub_exp[i]);

        // Reset mid-stream with three transfers in flight.
        bus_a.o_ready_i = 1'b0;
        send_a(400);
        send_a(401);
        send_a(402);
        bus_a.i_valid_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus_a.o_valid_o && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        check("midrst_pre_valid", 32'(bus_a.o_valid_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_drop", 32'(bus_a.o_valid_o), 0);
        check("midrst_data", 32'(bus_a.o_o), 0);
        check("midrst_err", 32'(bus_a.o_err_o), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(bus_a.i_ready_o), 1);
        @(posedge clk);
        #1;
        p0 = pops;
        bus_a.o_ready_i = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_stale", pops - p0, 0);
        lat_chk = 1'b1;
        s0 = seen.size();
        send_a(777);
        drain_a();
        lat_chk = 1'b0;
        check("midrst_new_count", pops - p0, 1);
        check("midrst_new_data", 32'(seen[s0]), 777);

        // Non-power-of-two instance: in range, first padded index, max select.
        probe_b(0, 1, 0);
        probe_b(599, 600, 0);
        probe_b(600, 0, 1);
        probe_b(1023, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
